multicycle_control: RTL and testbench

//  Multicycle RISC-V main control FSM: the sequencing side of the ALU interface. Drives alu_ctl, operand selects
//  and datapath strobes each cycle; consumes the ALU zero flag for beq. One instruction spans 3-5 states.

---
 rtl/riscv_pkg.sv | 51 +++++
 rtl/multicycle_control_if.sv | 45 ++++
 rtl/alu_decoder.sv | 32 +++
 rtl/multicycle_control.sv | 174 +++++++++++++++++
 tb/tb_multicycle_control.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// +--------------------------------------------------------------------------+
// | riscv_pkg                                                                |
// | Opcodes, ALU control codes, operand/result select encodings, FSM states. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package riscv_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

endpackage

`default_nettype wire

// File: rtl/multicycle_control_if.sv
// +--------------------------------------------------------------------------+
// | multicycle_control_if                                                    |
// | Controller <-> datapath/memory signal bundle.                            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface multicycle_control_if #(
    parameter int STATE_W = 4
);
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic               funct7_5;
    logic               zero;
    logic               mem_ready;
    logic [3:0]         alu_ctl;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         result_src;
    logic               adr_src;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               pc_write;
    logic               reg_write;
    logic               retire;
    logic               illegal;
    logic [STATE_W-1:0] dbg_state;

    modport master (
        input  opcode, funct3, funct7_5, zero, mem_ready,
        output alu_ctl, alu_src_a, alu_src_b, result_src, adr_src,
               mem_read, mem_write, ir_write, pc_write, reg_write,
               retire, illegal, dbg_state
    );

    modport slave (
        output opcode, funct3, funct7_5, zero, mem_ready,
        input  alu_ctl, alu_src_a, alu_src_b, result_src, adr_src,
               mem_read, mem_write, ir_write, pc_write, reg_write,
               retire, illegal, dbg_state
    );
endinterface

`default_nettype wire

// File: rtl/alu_decoder.sv
// +--------------------------------------------------------------------------+
// | alu_decoder                                                              |
// | funct3/funct7_5 -> ALU control code plus legality of the funct3 value.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_decoder
    import riscv_pkg::*;
(
    input  logic       is_rtype,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_ctl,
    output logic       legal
);

    always_comb begin
        alu_ctl = ALU_ADD;
        legal   = 1'b1;
        case (funct3)
            // funct7_5 only selects SUB for register-register ops.
            3'b000:  alu_ctl = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_ctl = ALU_AND;
            3'b110:  alu_ctl = ALU_OR;
            default: legal   = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// +--------------------------------------------------------------------------+
// | multicycle_control                                                       |
// | Multicycle RISC-V main control FSM. Optional: ILLEGAL_TRAP_EN.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module multicycle_control
    import riscv_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    state_e     state_q, state_d;
    logic [3:0] dec_alu_ctl;
    logic       dec_legal;
    logic       instr_legal;

    logic [3:0] alu_ctl;
    logic [1:0] src_a, src_b, res_src;
    logic       adr_src, mem_read, mem_write, ir_write, pc_write, reg_write, retire, illegal;

    alu_decoder u_alu_decoder (
        .is_rtype (bus.opcode == OP_R),
        .funct3   (bus.funct3),
        .funct7_5 (bus.funct7_5),
        .alu_ctl  (dec_alu_ctl),
        .legal    (dec_legal)
    );

    always_comb begin
        case (bus.opcode)
            OP_LW, OP_SW, OP_JAL: instr_legal = 1'b1;
            OP_R, OP_I:           instr_legal = dec_legal;
            OP_BEQ:               instr_legal = (bus.funct3 == 3'b000);
            default:              instr_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        alu_ctl   = ALU_ADD;
        src_a     = SRCA_PC;
        src_b     = SRCB_RS2;
        res_src   = RES_ALUOUT;
        adr_src   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        retire    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                src_b    = SRCB_FOUR;
                res_src  = RES_ALU;
                ir_write = bus.mem_ready;
                pc_write = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut.
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
                if (!instr_legal) begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    retire  = 1'b1;
                    state_d = S_FETCH;
`endif
                end else begin
                    case (bus.opcode)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_R:         state_d = S_EXECR;
                        OP_I:         state_d = S_EXECI;
                        OP_BEQ:       state_d = S_BEQ;
                        default:      state_d = S_JAL;
                    endcase
                end
            end
            S_MEMADR: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                state_d = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                res_src   = RES_MEMDATA;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                retire    = bus.mem_ready;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_RS2;
                alu_ctl = dec_alu_ctl;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                alu_ctl = dec_alu_ctl;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                src_a    = SRCA_RS1;
                src_b    = SRCB_RS2;
                alu_ctl  = ALU_SUB;
                pc_write = bus.zero;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                src_a    = SRCA_OLDPC;
                src_b    = SRCB_FOUR;
                pc_write = 1'b1;
                state_d  = S_ALUWB;
            end
            S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                illegal = 1'b1;
`else
                state_d = S_FETCH;
`endif
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Outputs are forced quiet for as long as reset is held, whatever the state.
    assign bus.alu_ctl    = rst_n ? alu_ctl : ALU_ADD;
    assign bus.alu_src_a  = rst_n ? src_a   : 2'b00;
    assign bus.alu_src_b  = rst_n ? src_b   : 2'b00;
    assign bus.result_src = rst_n ? res_src : 2'b00;
    assign bus.adr_src    = rst_n & adr_src;
    assign bus.mem_read   = rst_n & mem_read;
    assign bus.mem_write  = rst_n & mem_write;
    assign bus.ir_write   = rst_n & ir_write;
    assign bus.pc_write   = rst_n & pc_write;
    assign bus.reg_write  = rst_n & reg_write;
    assign bus.retire     = rst_n & retire;
    assign bus.illegal    = rst_n & illegal;
    assign bus.dbg_state  = STATE_W'(state_q);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// +--------------------------------------------------------------------------+
// | tb_multicycle_control                                                    |
// | Directed per-cycle vectors for the multicycle control FSM.               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_multicycle_control;
    import riscv_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    multicycle_control_if #(.STATE_W(4)) bus ();

    multicycle_control #(.STATE_W(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector: {alu_ctl, src_a, src_b, result_src, adr, mr, mw, irw, pcw, rw, retire, illegal}
    function automatic logic [17:0] v(input logic [3:0] alu, input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] res, input logic adr, input logic mr, input logic mw,
                                      input logic irw, input logic pcw, input logic rw, input logic ret,
                                      input logic ill);
        return {alu, a, b, res, adr, mr, mw, irw, pcw, rw, ret, ill};
    endfunction

    localparam logic [3:0] K_AND = 4'b0000;
    localparam logic [3:0] K_OR  = 4'b0001;
    localparam logic [3:0] K_ADD = 4'b0010;
    localparam logic [3:0] K_SUB = 4'b0110;

    logic [17:0] e_idle, e_f1, e_f0, e_dec, e_decr, e_aluwb, e_madr, e_mrd, e_mwb, e_mwr, e_mwr_r, e_trap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply mem_ready/zero, compare state and outputs, then advance one clock.
    task automatic step(input string tag, input logic mr, input logic z,
                        input logic [3:0] st, input logic [17:0] ev);
        bus.mem_ready = mr;
        bus.zero      = z;
        #1;
        check({tag, ".state"}, 32'(bus.dbg_state), 32'(st));
        check({tag, ".outs"},
              32'({bus.alu_ctl, bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.adr_src,
                   bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write, bus.reg_write,
                   bus.retire, bus.illegal}),
              32'(ev));
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7_5 = f7;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        step(tag, 1'b1, 1'b0, 4'd0, e_idle);
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        e_idle  = v(K_ADD, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        e_f1    = v(K_ADD, 2'b00, 2'b10, 2'b10, 0, 1, 0, 1, 1, 0, 0, 0);
        e_f0    = v(K_ADD, 2'b00, 2'b10, 2'b10, 0, 1, 0, 0, 0, 0, 0, 0);
        e_dec   = v(K_ADD, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        e_decr  = v(K_ADD, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
        e_aluwb = v(K_ADD, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0);
        e_madr  = v(K_ADD, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        e_mrd   = v(K_ADD, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0);
        e_mwb   = v(K_ADD, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 0, 1, 1, 0);
        e_mwr   = v(K_ADD, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0);
        e_mwr_r = v(K_ADD, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 1, 0);
        e_trap  = v(K_ADD, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);

        rst_n = 1'b0;
        instr(7'b0110011, 3'b000, 1'b0);
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b0;
        @(posedge clk);
        #1;
        step("reset", 1'b1, 1'b0, 4'd0, e_idle);
        rst_n = 1'b1;

        // add, with one fetch stall cycle
        step("add.fstall", 0, 0, 4'd0, e_f0);
        step("add.fetch",  1, 0, 4'd0, e_f1);
        step("add.dec",    0, 0, 4'd1, e_dec);
        step("add.exec",   0, 0, 4'd6, v(K_ADD, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        step("add.wb",     0, 0, 4'd8, e_aluwb);

        instr(7'b0110011, 3'b000, 1'b1);
        step("sub.fetch",  1, 0, 4'd0, e_f1);
        step("sub.dec",    1, 0, 4'd1, e_dec);
        step("sub.exec",   1, 0, 4'd6, v(K_SUB, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        step("sub.wb",     1, 0, 4'd8, e_aluwb);

        instr(7'b0110011, 3'b110, 1'b0);
        step("or.fetch",   1, 0, 4'd0, e_f1);
        step("or.dec",     1, 0, 4'd1, e_dec);
        step("or.exec",    1, 0, 4'd6, v(K_OR, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        step("or.wb",      1, 0, 4'd8, e_aluwb);

        instr(7'b0010011, 3'b111, 1'b1);
        step("andi.fetch", 1, 0, 4'd0, e_f1);
        step("andi.dec",   1, 0, 4'd1, e_dec);
        step("andi.exec",  1, 0, 4'd7, v(K_AND, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        step("andi.wb",    1, 0, 4'd8, e_aluwb);

        instr(7'b0010011, 3'b000, 1'b1);
        step("addi.fetch", 1, 0, 4'd0, e_f1);
        step("addi.dec",   1, 0, 4'd1, e_dec);
        step("addi.exec",  1, 0, 4'd7, v(K_ADD, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        step("addi.wb",    1, 0, 4'd8, e_aluwb);

        // lw with three wait cycles in MEMREAD
        instr(7'b0000011, 3'b010, 1'b0);
        step("lw.fetch",   1, 0, 4'd0, e_f1);
        step("lw.dec",     1, 0, 4'd1, e_dec);
        step("lw.madr",    1, 0, 4'd2, e_madr);
        for (int i = 0; i < 3; i++) step("lw.mrd_wait", 0, 0, 4'd3, e_mrd);
        step("lw.mrd",     1, 0, 4'd3, e_mrd);
        step("lw.wb",      1, 0, 4'd4, e_mwb);

        instr(7'b1100011, 3'b000, 1'b0);
        step("beq1.fetch", 1, 1, 4'd0, e_f1);
        step("beq1.dec",   1, 1, 4'd1, e_dec);
        step("beq1.br",    1, 1, 4'd9, v(K_SUB, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0));
        step("beq0.fetch", 1, 0, 4'd0, e_f1);
        step("beq0.dec",   1, 0, 4'd1, e_dec);
        step("beq0.br",    1, 0, 4'd9, v(K_SUB, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0));

        instr(7'b1101111, 3'b000, 1'b0);
        step("jal.fetch",  1, 0, 4'd0, e_f1);
        step("jal.dec",    1, 0, 4'd1, e_dec);
        step("jal.jal",    1, 0, 4'd10, v(K_ADD, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0));
        step("jal.wb",     1, 0, 4'd8, e_aluwb);

        instr(7'b0100011, 3'b010, 1'b0);
        step("sw.fetch",   1, 0, 4'd0, e_f1);
        step("sw.dec",     1, 0, 4'd1, e_dec);
        step("sw.madr",    1, 0, 4'd2, e_madr);
        for (int i = 0; i < 2; i++) step("sw.mwr_wait", 0, 0, 4'd5, e_mwr);
        step("sw.mwr",     1, 0, 4'd5, e_mwr_r);

        // unknown opcode
        instr(7'b1111111, 3'b000, 1'b0);
        step("ill.fetch",  1, 0, 4'd0, e_f1);
`ifdef ILLEGAL_TRAP_EN
        step("ill.dec",    1, 0, 4'd1, e_dec);
        for (int i = 0; i < 3; i++) step("ill.trap", 1, 0, 4'd11, e_trap);
        do_reset("ill.reset");
`else
        step("ill.dec",    1, 0, 4'd1, e_decr);
        step("ill.next",   1, 0, 4'd0, e_f1);
        step("ill.dec2",   1, 0, 4'd1, e_decr);
`endif

        // R-type with a funct3 that has no ALU op
        instr(7'b0110011, 3'b010, 1'b0);
        step("rill.fetch", 1, 0, 4'd0, e_f1);
`ifdef ILLEGAL_TRAP_EN
        step("rill.dec",   1, 0, 4'd1, e_dec);
        step("rill.trap",  1, 0, 4'd11, e_trap);
        do_reset("rill.reset");
`else
        step("rill.dec",   1, 0, 4'd1, e_decr);
`endif

        // beq with non-zero funct3
        instr(7'b1100011, 3'b001, 1'b0);
        step("bill.fetch", 1, 0, 4'd0, e_f1);
`ifdef ILLEGAL_TRAP_EN
        step("bill.dec",   1, 0, 4'd1, e_dec);
        step("bill.trap",  1, 0, 4'd11, e_trap);
        do_reset("bill.reset");
`else
        step("bill.dec",   1, 0, 4'd1, e_decr);
`endif

        // reset during a stalled store
        instr(7'b0100011, 3'b010, 1'b0);
        step("rsw.fetch",  1, 0, 4'd0, e_f1);
        step("rsw.dec",    1, 0, 4'd1, e_dec);
        step("rsw.madr",   1, 0, 4'd2, e_madr);
        step("rsw.mwr",    0, 0, 4'd5, e_mwr);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        step("rsw.inrst",  0, 0, 4'd0, e_idle);
        rst_n = 1'b1;
        step("rsw.after",  0, 0, 4'd0, e_f0);
        step("rsw.refetch", 1, 0, 4'd0, e_f1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
